spike_counter_bank: RTL and testbench

//  Multi-channel successor to the single-channel spike counter. Counts rising edges on NCH spike

---
 rtl/spike_counter_bank.sv | 126 ++++++++++++
 tb/tb_spike_counter_bank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_counter_bank.sv
// Multi-channel spike rate counter: synchronised rising-edge counts per channel over a
// programmable window, snapshotted to an output bank with a one-cycle valid pulse.
module spike_counter_bank #(
    parameter int unsigned NCH         = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   slow_clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         spike,
    input  logic                   enable,
    input  logic                   mode,
    input  logic [WIN_W-1:0]       window_len,
    input  logic                   clear,
    output logic [NCH*CNT_W-1:0]   cnt_out,
    output logic                   cnt_valid,
    output logic [NCH-1:0]         sat_out,
    output logic [WIN_W-1:0]       win_pos
);

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
    logic [NCH-1:0]                  prev_q;
    logic [NCH-1:0]                  spike_edge;

    logic [NCH-1:0][CNT_W-1:0] acc_q;
    logic [NCH-1:0][CNT_W-1:0] acc_sum;
    logic [NCH-1:0][CNT_W-1:0] bank_q;
    logic [NCH-1:0]            sat_q;
    logic [NCH-1:0]            sat_sum;
    logic [NCH-1:0]            sat_bank_q;

    logic [WIN_W-1:0] pos_q;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] len_in;
    logic [WIN_W-1:0] len_eff;
    logic             first_q;
    logic             valid_q;
    logic             boundary;

    // Sync and prev flops run regardless of enable so re-enabling never fabricates an edge.
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= spike;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign spike_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

    assign len_in  = (window_len == '0) ? WIN_W'(1) : window_len;
    // First cycle after reset uses the live length, since len_q has not been loaded yet.
    assign len_eff = first_q ? len_in : len_q;
    assign boundary = enable && !clear && (pos_q == len_eff - WIN_W'(1));

    // A full accumulator holds; an edge arriving while full marks the channel saturated.
    always_comb begin
        acc_sum = '0;
        sat_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            if (&acc_q[i]) begin
                acc_sum[i] = acc_q[i];
                sat_sum[i] = sat_q[i] | spike_edge[i];
            end else begin
                acc_sum[i] = acc_q[i] + CNT_W'(spike_edge[i]);
                sat_sum[i] = sat_q[i];
            end
        end
    end

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            sat_q      <= '0;
            bank_q     <= '0;
            sat_bank_q <= '0;
            pos_q      <= '0;
            len_q      <= '0;
            first_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            first_q <= 1'b0;
            valid_q <= boundary;
            if (clear) begin
                acc_q <= '0;
                sat_q <= '0;
                pos_q <= '0;
                len_q <= len_in;
            end else begin
                if (first_q || boundary) begin
                    len_q <= len_in;
                end
                if (enable) begin
                    if (boundary) begin
                        bank_q     <= acc_sum;
                        sat_bank_q <= sat_sum;
                        pos_q      <= '0;
                        if (mode) begin
                            acc_q <= acc_sum;
                            sat_q <= sat_sum;
                        end else begin
                            acc_q <= '0;
                            sat_q <= '0;
                        end
                    end else begin
                        acc_q <= acc_sum;
                        sat_q <= sat_sum;
                        pos_q <= pos_q + WIN_W'(1);
                    end
                end
            end
        end
    end

    assign cnt_out   = bank_q;
    assign cnt_valid = valid_q;
    assign sat_out   = sat_bank_q;
    assign win_pos   = pos_q;

endmodule

// File: tb/tb_spike_counter_bank.sv
// Bench for spike_counter_bank: directed scenarios plus random traffic, all checked against
// a count-based reference model of windows, latency and saturation.
module tb_spike_counter_bank;

    localparam int NCH   = 8;
    localparam int CNT_W = 4;
    localparam int WIN_W = 16;
    localparam int SYNC  = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic                 slow_clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       spike;
    logic                 enable;
    logic                 mode;
    logic [WIN_W-1:0]     window_len;
    logic                 clear;
    logic [NCH*CNT_W-1:0] cnt_out;
    logic                 cnt_valid;
    logic [NCH-1:0]       sat_out;
    logic [WIN_W-1:0]     win_pos;

    spike_counter_bank #(
        .NCH         (NCH),
        .CNT_W       (CNT_W),
        .WIN_W       (WIN_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .slow_clk   (slow_clk),
        .reset      (reset),
        .spike      (spike),
        .enable     (enable),
        .mode       (mode),
        .window_len (window_len),
        .clear      (clear),
        .cnt_out    (cnt_out),
        .cnt_valid  (cnt_valid),
        .sat_out    (sat_out),
        .win_pos    (win_pos)
    );

    always #5 slow_clk = ~slow_clk;

    int nerr = 0;
    int nchk = 0;

    // Reference model: true edge counts, sampled-spike history, window position and length.
    int             n_cnt [NCH];
    logic [NCH-1:0] hist [SYNC+2];
    int             m_pos;
    int             m_len;
    bit             m_first;
    int             exp_cnt [NCH];
    logic [NCH-1:0] exp_sat;
    logic           exp_valid;

    function automatic int fixlen(input logic [WIN_W-1:0] wl);
        return (wl == 0) ? 1 : int'(wl);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            n_cnt[i] = 0;
            exp_cnt[i] = 0;
        end
        for (int j = 0; j < SYNC + 2; j++) hist[j] = '0;
        m_pos = 0;
        m_len = 1;
        m_first = 1'b1;
        exp_sat = '0;
        exp_valid = 1'b0;
    endtask

    task automatic model_edge();
        logic [NCH-1:0] rise;
        for (int j = SYNC + 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = spike;
        rise = hist[SYNC] & ~hist[SYNC+1];
        if (m_first) m_len = fixlen(window_len);
        m_first = 1'b0;
        exp_valid = 1'b0;
        if (clear) begin
            for (int i = 0; i < NCH; i++) n_cnt[i] = 0;
            m_pos = 0;
            m_len = fixlen(window_len);
        end else if (enable) begin
            for (int i = 0; i < NCH; i++) n_cnt[i] += int'(rise[i]);
            if (m_pos == m_len - 1) begin
                for (int i = 0; i < NCH; i++) begin
                    exp_cnt[i] = (n_cnt[i] > MAXC) ? MAXC : n_cnt[i];
                    exp_sat[i] = (n_cnt[i] > MAXC);
                    if (!mode) n_cnt[i] = 0;
                end
                exp_valid = 1'b1;
                m_pos = 0;
                m_len = fixlen(window_len);
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] chan(input int i);
        return cnt_out[i*CNT_W +: CNT_W];
    endfunction

    task automatic check_all();
        for (int i = 0; i < NCH; i++) chk($sformatf("cnt_ch%0d", i), 32'(chan(i)), exp_cnt[i]);
        chk("sat_out", 32'(sat_out), 32'(exp_sat));
        chk("cnt_valid", 32'(cnt_valid), 32'(exp_valid));
        chk("win_pos", 32'(win_pos), m_pos);
    endtask

    task automatic step(input logic [NCH-1:0] sp, input logic en, input logic md,
                        input logic clr, input logic [WIN_W-1:0] wl);
        spike = sp;
        enable = en;
        mode = md;
        clear = clr;
        window_len = wl;
        @(posedge slow_clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_cnt_out", 32'(cnt_out != '0), 0);
        chk("rst_sat_out", 32'(sat_out), 0);
        chk("rst_cnt_valid", 32'(cnt_valid), 0);
        chk("rst_win_pos", 32'(win_pos), 0);
        model_reset();
        @(posedge slow_clk);
        #1;
        reset = 1'b0;
    endtask

    logic           r_mode;
    logic [WIN_W-1:0] r_wl;

    initial begin
        spike = '0;
        enable = 1'b1;
        mode = 1'b0;
        clear = 1'b0;
        window_len = 16'd10;
        do_reset();

        // T1: windowed, len 10
        for (int k = 0; k < 10; k++) begin
            step({6'b0, (k >= 2 && k <= 6) ? 1'b1 : 1'b0,
                  (k == 1 || k == 3 || k == 5) ? 1'b1 : 1'b0}, 1'b1, 1'b0, 1'b0, 16'd10);
        end
        chk("t1_ch0", 32'(chan(0)), 3);
        chk("t1_ch1", 32'(chan(1)), 1);
        chk("t1_valid", 32'(cnt_valid), 1);
        step('0, 1'b1, 1'b0, 1'b0, 16'd10);
        chk("t1_valid_pulse", 32'(cnt_valid), 0);

        // T2: edge landing on the boundary cycle counts in the closing window
        step(8'h04, 1'b1, 1'b0, 1'b1, 16'd4);
        step(8'h00, 1'b1, 1'b0, 1'b0, 16'd4);
        step(8'h04, 1'b1, 1'b0, 1'b0, 16'd4);
        step(8'h00, 1'b1, 1'b0, 1'b0, 16'd4);
        step(8'h00, 1'b1, 1'b0, 1'b0, 16'd4);
        chk("t2_ch2", 32'(chan(2)), 2);
        for (int k = 0; k < 4; k++) step('0, 1'b1, 1'b0, 1'b0, 16'd4);
        chk("t2_ch2_next", 32'(chan(2)), 0);

        // T3: saturation at 15 with 20 edges
        step(8'h08, 1'b1, 1'b0, 1'b1, 16'd40);
        for (int k = 1; k <= 40; k++) begin
            step((k % 2 == 0 && k < 40) ? 8'h08 : 8'h00, 1'b1, 1'b0, 1'b0, 16'd40);
        end
        chk("t3_ch3", 32'(chan(3)), 15);
        chk("t3_sat3", 32'(sat_out[3]), 1);
        for (int k = 0; k < 40; k++) step('0, 1'b1, 1'b0, 1'b0, 16'd40);
        chk("t3_ch3_quiet", 32'(chan(3)), 0);
        chk("t3_sat3_quiet", 32'(sat_out[3]), 0);

        // T4: cumulative mode, then clear restarts from zero
        step('0, 1'b1, 1'b1, 1'b1, 16'd5);
        for (int w = 1; w <= 4; w++) begin
            for (int k = 0; k < 5; k++) step((k == 0 || k == 2) ? 8'h01 : 8'h00,
                                             1'b1, 1'b1, 1'b0, 16'd5);
            chk($sformatf("t4_snap%0d", w), 32'(chan(0)), 2 * w);
        end
        step('0, 1'b1, 1'b1, 1'b1, 16'd5);
        for (int k = 0; k < 5; k++) step((k == 0 || k == 2) ? 8'h01 : 8'h00,
                                         1'b1, 1'b1, 1'b0, 16'd5);
        chk("t4_after_clear", 32'(chan(0)), 2);

        // T5: enable low while spike rises: lost edge, frozen window, no edge on re-enable
        step('0, 1'b1, 1'b0, 1'b1, 16'd10);
        for (int k = 0; k < 3; k++) step('0, 1'b1, 1'b0, 1'b0, 16'd10);
        for (int k = 0; k < 7; k++) step(8'h20, 1'b0, 1'b0, 1'b0, 16'd10);
        chk("t5_pos_frozen", 32'(win_pos), 3);
        for (int k = 0; k < 7; k++) step(8'h20, 1'b1, 1'b0, 1'b0, 16'd10);
        chk("t5_ch5", 32'(chan(5)), 0);
        chk("t5_valid", 32'(cnt_valid), 1);
        step('0, 1'b1, 1'b0, 1'b0, 16'd10);

        // T6: mid-window length change waits for the boundary; async reset clears at once
        step(8'h01, 1'b1, 1'b0, 1'b1, 16'd3);
        for (int k = 0; k < 3; k++) step('0, 1'b1, 1'b0, 1'b0, 16'd3);
        chk("t6_ch0_a", 32'(chan(0)), 1);
        step(8'h01, 1'b1, 1'b0, 1'b0, 16'd7);
        step(8'h00, 1'b1, 1'b0, 1'b0, 16'd7);
        step(8'h01, 1'b1, 1'b0, 1'b0, 16'd7);
        chk("t6_old_len_bnd", 32'(cnt_valid), 1);
        chk("t6_ch0_b", 32'(chan(0)), 1);
        for (int k = 0; k < 6; k++) step((k % 2 == 1) ? 8'h01 : 8'h00, 1'b1, 1'b0, 1'b0, 16'd7);
        chk("t6_new_len_pos", 32'(win_pos), 6);
        chk("t6_no_bnd_yet", 32'(cnt_valid), 0);
        do_reset();
        for (int k = 0; k < 7; k++) step('0, 1'b1, 1'b0, 1'b0, 16'd7);
        chk("t6_post_reset_bnd", 32'(cnt_valid), 1);

        // Random traffic
        r_mode = 1'b0;
        r_wl = 16'd5;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            if ($urandom_range(0, 39) == 0) r_mode = ~r_mode;
            if ($urandom_range(0, 19) == 0) r_wl = 16'($urandom_range(0, 9));
            step(NCH'($urandom & $urandom), ($urandom_range(0, 9) != 0), r_mode,
                 ($urandom_range(0, 49) == 0), r_wl);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
